// File: rtl/fuzzy_pkg.sv
// Shared constants, FSM state encoding and round-robin pick for the fuzzy numerator scheduler.
package fuzzy_pkg;

  localparam int N_REQ = 4;
  localparam int W = 32;
  localparam int KW = 8;
  localparam logic [KW-1:0] K = 8'd100;
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    OUT  = 2'd3
  } state_t;

  // First requester strictly after 'last', wrapping; returns 'last' when nobody requests.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx_b;
    logic           found;
    int             idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx   = (int'(last) + off) % N_REQ;
      idx_b = IDW'(idx);
      if (!found && req[idx_b]) begin
        pick  = idx_b;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fuzzy_mult_k.sv
// Combinational W x KW multiply by the constant K with overflow flag.
// MULT_SAT_EN defined: overflowing results saturate to all ones; otherwise they wrap mod 2^W.
module fuzzy_mult_k #(
  parameter int W = fuzzy_pkg::W,
  parameter int KW = fuzzy_pkg::KW,
  parameter logic [KW-1:0] K = fuzzy_pkg::K
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] p,
  output logic         ovf
);

  logic [W+KW-1:0] prod;

  assign prod = {{KW{1'b0}}, a} * {{W{1'b0}}, K};
  assign ovf  = |prod[W+KW-1:W];

`ifdef MULT_SAT_EN
  assign p = ovf ? {W{1'b1}} : prod[W-1:0];
`else
  assign p = prod[W-1:0];
`endif

endmodule

// File: rtl/fuzzy_numerador_scheduler.sv
// Round-robin scheduler sharing one multiply-by-K unit among N_REQ membership units.
// Build option MULT_SAT_EN (in fuzzy_mult_k) selects saturation instead of wrap on overflow.
//
// state | meaning
// IDLE  | arbitrate; combinational gnt pulse, latch operands of the winner
// MUL1  | register num1*K
// MUL2  | register num2*K, raise res_valid
// OUT   | hold result until res_ready
module fuzzy_numerador_scheduler #(
  parameter int N_REQ = fuzzy_pkg::N_REQ,
  parameter int W = fuzzy_pkg::W,
  parameter int KW = fuzzy_pkg::KW,
  parameter logic [KW-1:0] K = fuzzy_pkg::K
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         num1_in,
  input  logic [N_REQ*W-1:0]         num2_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [W-1:0]               num1_mult,
  output logic [W-1:0]               num2_mult,
  output logic                       ovf
);

  import fuzzy_pkg::state_t;
  import fuzzy_pkg::IDLE;
  import fuzzy_pkg::MUL1;
  import fuzzy_pkg::MUL2;
  import fuzzy_pkg::OUT;
  import fuzzy_pkg::rr_pick;

  localparam int IDW = $clog2(N_REQ);

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] pick;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_p;
  logic           mul_ovf;
  logic [W-1:0]   num1_arr [N_REQ];
  logic [W-1:0]   num2_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign num1_arr[g] = num1_in[g*W +: W];
    assign num2_arr[g] = num2_in[g*W +: W];
  end

  assign pick  = rr_pick(req, last);
  assign busy  = (state != IDLE);
  assign mul_a = (state == MUL2) ? op2 : op1;

  // Grant is decided in the IDLE cycle itself; held off while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && (state == IDLE) && (|req)) gnt[pick] = 1'b1;
  end

  fuzzy_mult_k #(
    .W  (W),
    .KW (KW),
    .K  (K)
  ) u_mult (
    .a   (mul_a),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(N_REQ - 1);
      op1       <= '0;
      op2       <= '0;
      res_id    <= '0;
      num1_mult <= '0;
      num2_mult <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            op1    <= num1_arr[pick];
            op2    <= num2_arr[pick];
            res_id <= pick;
            last   <= pick;
            ovf    <= 1'b0;
            state  <= MUL1;
          end
        end
        MUL1: begin
          num1_mult <= mul_p;
          ovf       <= mul_ovf;
          state     <= MUL2;
        end
        MUL2: begin
          num2_mult <= mul_p;
          ovf       <= ovf | mul_ovf;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzzy_numerador_scheduler.sv
// Scoreboard bench for fuzzy_numerador_scheduler: directed vectors, expected results queued at grant.
module tb_fuzzy_numerador_scheduler;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [127:0]  num1_in;
  logic [127:0]  num2_in;
  logic [3:0]    gnt;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_id;
  logic [31:0]   num1_mult;
  logic [31:0]   num2_mult;
  logic          ovf;
  logic [31:0]   n1 [4];
  logic [31:0]   n2 [4];

  typedef struct {
    int          id;
    logic [31:0] m1;
    logic [31:0] m2;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  assign num1_in = {n1[3], n1[2], n1[1], n1[0]};
  assign num2_in = {n2[3], n2[2], n2[1], n2[0]};

  always #5 clk = ~clk;

  fuzzy_numerador_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .num1_in   (num1_in),
    .num2_in   (num2_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .num1_mult (num1_mult),
    .num2_mult (num2_mult),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic next_gnt(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == 4'b0 && cyc < 12);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops one expectation per accepted result.
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got id %0d expected none", res_id);
        end else begin
          e = sb.pop_front();
          chk("res_id", 64'(res_id), 64'(e.id));
          chk("num1_mult", 64'(num1_mult), 64'(e.m1));
          chk("num2_mult", 64'(num2_mult), 64'(e.m2));
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [3:0]  ord [5] = '{0, 1, 2, 3, 0};
  logic [31:0] e1  [4] = '{32'd500, 32'd1700, 32'd25000, 32'd100000};
  logic [31:0] e2  [4] = '{32'd900, 32'd3300, 32'd7700, 32'd40000};
  logic [31:0] sat_exp;

  initial begin
    int cyc;
    int cnt;
`ifdef MULT_SAT_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'h2C00_0000;
`endif
    rst_n = 1'b0;
    req = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n1[i] = 32'd0;
      n2[i] = 32'd0;
    end

    // Reset state, with requests pending that must not be granted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_m1", 64'(num1_mult), 64'd0);
    chk("rst_m2", 64'(num2_mult), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    drive_slot();
    req = 4'b0;
    rst_n = 1'b1;

    // T1: single request, latency
    drive_slot();
    n1[0] = 32'd37;
    n2[0] = 32'd63;
    req = 4'b0001;
    sb.push_back('{0, 32'd3700, 32'd6300, 1'b0});
    @(negedge clk);
    chk("t1_gnt", 64'(gnt), 64'b0001);
    chk("t1_busy_c0", 64'(busy), 64'd0);
    drive_slot();
    req = 4'b0;
    @(negedge clk);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    chk("t1_valid_c1", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_c2", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_c3", 64'(res_valid), 64'd1);
    @(negedge clk);
    chk("t1_valid_c4", 64'(res_valid), 64'd0);
    drain();

    // T2: all request after reset, RR order and spacing
    drive_slot();
    rst_n = 1'b0;
    drive_slot();
    rst_n = 1'b1;
    n1[0] = 32'd5;   n2[0] = 32'd9;
    n1[1] = 32'd17;  n2[1] = 32'd33;
    n1[2] = 32'd250; n2[2] = 32'd77;
    n1[3] = 32'd1000; n2[3] = 32'd400;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      next_gnt(cyc);
      chk("t2_gnt", 64'(gnt), 64'(4'b0001 << ord[k]));
      chk("t2_spacing", 64'(cyc), (k == 0) ? 64'd1 : 64'd4);
      sb.push_back('{int'(ord[k]), e1[ord[k][1:0]], e2[ord[k][1:0]], 1'b0});
    end
    drive_slot();
    req = 4'b0;
    drain();

    // T3: back-pressure holds outputs and blocks grants
    drive_slot();
    res_ready = 1'b0;
    n1[2] = 32'd1234;
    n2[2] = 32'd56;
    req = 4'b0100;
    next_gnt(cyc);
    chk("t3_gnt", 64'(gnt), 64'b0100);
    sb.push_back('{2, 32'd123400, 32'd5600, 1'b0});
    drive_slot();
    req = 4'b1011;
    cnt = 0;
    while (!res_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3_valid_seen", 64'(res_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_gnt", 64'(gnt), 64'd0);
      chk("t3_hold_m1", 64'(num1_mult), 64'd123400);
      chk("t3_hold_m2", 64'(num2_mult), 64'd5600);
      chk("t3_hold_id", 64'(res_id), 64'd2);
      chk("t3_hold_valid", 64'(res_valid), 64'd1);
      if (i < 4) @(negedge clk);
    end
    drive_slot();
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept_gnt", 64'(gnt), 64'd0);
    sb.push_back('{3, 32'd100000, 32'd40000, 1'b0});
    next_gnt(cyc);
    chk("t3_next_gnt", 64'(gnt), 64'b1000);
    chk("t3_next_delay", 64'(cyc), 64'd1);
    drive_slot();
    req = 4'b0;
    drain();

    // T4: overflow on num1
    drive_slot();
    n1[1] = 32'h0300_0000;
    n2[1] = 32'd7;
    req = 4'b0010;
    next_gnt(cyc);
    chk("t4_gnt", 64'(gnt), 64'b0010);
    sb.push_back('{1, sat_exp, 32'd700, 1'b1});
    drive_slot();
    req = 4'b0;
    drain();

    // T5: zero and largest non-overflowing operand
    drive_slot();
    n1[0] = 32'd0;
    n2[0] = 32'd42949672;
    req = 4'b0001;
    next_gnt(cyc);
    chk("t5_gnt", 64'(gnt), 64'b0001);
    sb.push_back('{0, 32'd0, 32'd4294967200, 1'b0});
    drive_slot();
    req = 4'b0;
    drain();

    // T6: reset during MUL2 drops the result
    drive_slot();
    n1[2] = 32'd8;
    n2[2] = 32'd9;
    req = 4'b0100;
    next_gnt(cyc);
    chk("t6_gnt", 64'(gnt), 64'b0100);
    drive_slot();
    req = 4'b0;
    drive_slot();
    chk("t6_mid_m1", 64'(num1_mult), 64'd800);
    rst_n = 1'b0;
    req = 4'b1010;
    #1;
    chk("t6_rst_gnt", 64'(gnt), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valid", 64'(res_valid), 64'd0);
    chk("t6_rst_id", 64'(res_id), 64'd0);
    chk("t6_rst_m1", 64'(num1_mult), 64'd0);
    chk("t6_rst_m2", 64'(num2_mult), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    drive_slot();
    n1[1] = 32'd11;
    n2[1] = 32'd22;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_first_gnt", 64'(gnt), 64'b0010);
    sb.push_back('{1, 32'd1100, 32'd2200, 1'b0});
    drive_slot();
    req = 4'b0;
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
